// File: rtl/pc_pkg.sv
// Shared definitions for the PC fetch unit: FSM states and default widths and vectors.
package pc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } pc_state_t;

    localparam int unsigned PC_NBITS_DEFAULT    = 7;
    localparam int unsigned RESET_PC_DEFAULT    = 0;
    localparam int unsigned PC_LIMIT_DEFAULT    = 127;
    localparam int unsigned TRAP_VECTOR_DEFAULT = 0;

endpackage

// File: rtl/pc_fetch_unit_pc_limit_check.sv
// PC range comparator: substitutes TRAP_VECTOR for any next PC above PC_LIMIT.
// Instantiated by pc_fetch_unit only when PC_LIMIT_TRAP_EN is defined.
module pc_limit_check
    import pc_pkg::*;
#(
    parameter int unsigned      nbits       = PC_NBITS_DEFAULT,
    parameter logic [nbits-1:0] PC_LIMIT    = nbits'(PC_LIMIT_DEFAULT),
    parameter logic [nbits-1:0] TRAP_VECTOR = nbits'(TRAP_VECTOR_DEFAULT)
) (
    input  logic [nbits-1:0] i_next_pc,
    output logic [nbits-1:0] o_load_pc,
    output logic             o_trap
);

    logic w_over;

    assign w_over    = (i_next_pc > PC_LIMIT);
    assign o_load_pc = w_over ? TRAP_VECTOR : i_next_pc;
    assign o_trap    = w_over;

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer (BOOT/FETCH/HOLD) with req/ack instruction fetch.
// Optional out-of-range trap is enabled by defining PC_LIMIT_TRAP_EN.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int unsigned      nbits       = PC_NBITS_DEFAULT,
    parameter logic [nbits-1:0] RESET_PC    = nbits'(RESET_PC_DEFAULT),
    parameter logic [nbits-1:0] PC_LIMIT    = nbits'(PC_LIMIT_DEFAULT),
    parameter logic [nbits-1:0] TRAP_VECTOR = nbits'(TRAP_VECTOR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [nbits-1:0] next_pc,
    input  logic             redirect,
    input  logic             stall,
    input  logic             imem_ack,
    output logic [nbits-1:0] pc,
    output logic [nbits-1:0] pc_inc,
    output logic             fetch_req,
    output logic             inst_valid,
    output logic             flush,
    output logic             trap
);

    pc_state_t        r_state;
    logic [nbits-1:0] r_pc;
    logic             r_inst_valid;
    logic             r_flush;
    logic             r_trap;

    logic [nbits-1:0] w_load_pc;
    logic             w_load_trap;

    // A trap vector outside the legal range would re-trap forever.
    if (TRAP_VECTOR > PC_LIMIT) begin : g_cfg_check
        $error("pc_fetch_unit: TRAP_VECTOR must not exceed PC_LIMIT");
    end

`ifdef PC_LIMIT_TRAP_EN
    pc_limit_check #(
        .nbits       (nbits),
        .PC_LIMIT    (PC_LIMIT),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) u_limit_check (
        .i_next_pc (next_pc),
        .o_load_pc (w_load_pc),
        .o_trap    (w_load_trap)
    );
`else
    assign w_load_pc   = next_pc;
    assign w_load_trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BOOT;
            r_pc         <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_flush      <= 1'b0;
            r_trap       <= 1'b0;
        end else begin
            r_inst_valid <= 1'b0;
            r_flush      <= 1'b0;
            r_trap       <= 1'b0;
            unique case (r_state)
                BOOT: r_state <= FETCH;
                FETCH: begin
                    // Redirect drops the outstanding request even if it is acked now.
                    if (redirect) begin
                        r_pc    <= w_load_pc;
                        r_flush <= 1'b1;
                        r_trap  <= w_load_trap;
                    end else if (stall) begin
                        r_state <= HOLD;
                    end else if (imem_ack) begin
                        r_pc         <= w_load_pc;
                        r_inst_valid <= 1'b1;
                        r_trap       <= w_load_trap;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_load_pc;
                        r_flush <= 1'b1;
                        r_trap  <= w_load_trap;
                        r_state <= FETCH;
                    end else if (!stall) begin
                        r_state <= FETCH;
                    end
                end
                default: r_state <= BOOT;
            endcase
        end
    end

    assign pc         = r_pc;
    assign pc_inc     = r_pc + nbits'(1);
    assign fetch_req  = (r_state == FETCH);
    assign inst_valid = r_inst_valid;
    assign flush      = r_flush;
    assign trap       = r_trap;

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and fetch sequencer for the pipeline front end. Holds the current PC, produces `pc_inc` (PC+1) for the next-PC select mux and consumes that mux's selected result as `next_pc`. Issues fetch requests to instruction memory with a req/ack handshake. Handles stalls, branch redirects and an optional out-of-range trap.

## Interface
- `nbits`, 7: PC width.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_LIMIT`, 7'h7F: highest legal PC (used only with `PC_LIMIT_TRAP_EN`).
- `TRAP_VECTOR`, 7'h00: PC loaded on trap (used only with `PC_LIMIT_TRAP_EN`).

- `clk` input 1: clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `next_pc` input nbits: selected next PC from the next-PC mux.
- `redirect` input 1: branch taken this cycle; `next_pc` holds the target.
- `stall` input 1: downstream hazard; freeze the PC.
- `imem_ack` input 1: instruction memory accepted/served the current request.
- `pc` output nbits: current fetch address.
- `pc_inc` output nbits: `pc + 1` mod 2^nbits, combinational from `pc`.
- `fetch_req` output 1: fetch request for address `pc`.
- `inst_valid` output 1: one-cycle pulse when a fetch completes and is kept.
- `flush` output 1: one-cycle pulse after a redirect; younger stages squash.
- `trap` output 1: one-cycle pulse on limit violation; stays 0 when the feature is compiled out.

## Operation
- FSM states: BOOT, FETCH, HOLD.
- Reset values: state=BOOT, `pc`=RESET_PC, `fetch_req`=0, `inst_valid`=0, `flush`=0, `trap`=0.
- BOOT: idle for one cycle, then move to FETCH. A `redirect` during BOOT is ignored.
- FETCH: `fetch_req`=1.
  - `redirect`=1: `pc`<=`next_pc`, `flush`<=1, `inst_valid`<=0. The outstanding request is dropped, even if `imem_ack`=1 in the same cycle. Stay in FETCH.
  - `stall`=1 (no redirect): move to HOLD. `pc` is unchanged. An `imem_ack` in the same cycle is not consumed, and the request is reissued after the stall.
  - `imem_ack`=1 (no redirect or stall): `inst_valid`<=1, `pc`<=`next_pc`.
  - No `imem_ack`: hold `pc` and keep `fetch_req` asserted.
- HOLD: `fetch_req`=0.
  - `redirect` in HOLD takes priority: `pc`<=`next_pc`, `flush`<=1, move to FETCH.
  - `stall` deasserted: move to FETCH.
- Priority: rst > redirect > stall > imem_ack.
- Arithmetic: `pc_inc` wraps, so 7'h7F+1 = 7'h00. No saturation.
- Reset asserted mid-fetch: all state returns to reset values immediately. The pending request is abandoned and `fetch_req` drops asynchronously.

## Timing
- Registered outputs: `pc`, `inst_valid`, `flush`, `trap`.
- `fetch_req` decodes from the state register.
- Latency:
  - `imem_ack` to `inst_valid` high: 1 cycle.
  - `redirect` to `pc`=target and `flush`=1: 1 cycle. The first fetch of the target is requested that same cycle.
  - Stall release to `fetch_req`: 1 cycle.
- Back-to-back acks give one instruction per cycle.
- `pc_inc` tracks `pc` with zero latency. The mux and next_pc path must close within one cycle.

## Configuration
- `PC_LIMIT_TRAP_EN` defined:
  - Any PC load (sequential or redirect) whose `next_pc` > PC_LIMIT loads TRAP_VECTOR instead.
  - `trap`<=1 for one cycle. On a redirect, `flush` is also asserted.
- Undefined: the load proceeds with the raw `next_pc` (natural wrap), `trap` is tied to 0, and no compare logic is built.

## Structure
- Shared package `pc_pkg`:
  - FSM state enum (BOOT, FETCH, HOLD).
  - Default widths.
  - RESET_PC / TRAP_VECTOR defaults.
- One sub-module: `pc_limit_check` (comparator and vector substitution), instantiated only under `PC_LIMIT_TRAP_EN`.
- The FSM and the PC register stay in the top module.

## Test plan
- Reset release: `pc`=0 in BOOT; `fetch_req` rises on the 2nd edge; acks every cycle with `next_pc`=`pc_inc` → `pc` steps 0,1,2,3 and `inst_valid` is high each cycle.
- Wrap: start at `pc`=7'h7E, sequential acks → 7'h7F then 7'h00, with `pc_inc` 7'h00 then 7'h01.
- Redirect with simultaneous ack at `pc`=5, `next_pc`=7'h40 → next cycle `pc`=7'h40, `flush`=1, `inst_valid`=0.
- Stall for 3 cycles at `pc`=9 with `imem_ack` held high → `pc` stays 9, `fetch_req`=0 during the stall; `fetch_req` reasserts 1 cycle after release; the next ack advances to 10.
- Trap (macro on, PC_LIMIT=7'h3F, TRAP_VECTOR=7'h10): redirect to 7'h50 → `pc`=7'h10, `trap`=1, `flush`=1. Macro off: `pc`=7'h50, `trap`=0.
- Asynchronous reset asserted mid-wait (`fetch_req`=1, no ack) → `pc`=0 and `fetch_req`=0 before the next clock edge; normal BOOT sequence after release.
